// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR controller: one shared saturating multiplier, TAPS MAC cycles per sample.
// Latency: result valid TAPS+1 cycles after the accept cycle; one sample per TAPS+2 cycles.
// Backpressure: result held in OUT until out_ready; in_ready stays low until the result drains.
// Optional: define FIR_SAT_FLAG_EN to add out_sat (accumulator clamp seen during this result).
module fir_mac_sched #(
    parameter int TAPS = 4,
    parameter int IW   = 2
) (
    input  logic          system1000,
    input  logic          system1000_rstn,
    input  logic          coef_we,
    input  logic [IW-1:0] coef_addr,
    input  logic [15:0]   coef_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic [15:0]   mul_a,
    output logic [15:0]   mul_b,
    input  logic [15:0]   mul_res,
    output logic          busy
`ifdef FIR_SAT_FLAG_EN
    ,
    output logic          out_sat
`endif
);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam logic [IW-1:0] LAST   = IW'(TAPS - 1);
    localparam logic [IW:0]   TAPS_W = (IW + 1)'(TAPS);

    state_t        state;
    logic [15:0]   coef   [TAPS];
    logic [15:0]   sample [TAPS];
    logic [IW-1:0] wptr;
    logic [IW-1:0] k;
    logic [15:0]   acc;

    logic          accept;
    logic [IW:0]   diff;
    logic [IW-1:0] sidx;
    logic [16:0]   sum17;
    logic          clamp;
    logic [15:0]   acc_next;

    assign accept = (state == IDLE) && in_valid && in_ready;

    // Delay-line index (wptr - k) mod TAPS, valid for any TAPS, plus the operand mux to the multiplier.
    always_comb begin
        diff  = {1'b0, wptr} + TAPS_W - {1'b0, k};
        sidx  = (diff >= TAPS_W) ? IW'(diff - TAPS_W) : IW'(diff);
        mul_a = '0;
        mul_b = '0;
        if (state == MAC) begin
            mul_a = coef[k];
            mul_b = sample[sidx];
        end
    end

    // Saturating accumulate step: clamp every partial sum, not just the final one.
    always_comb begin
        sum17    = {acc[15], acc} + {mul_res[15], mul_res};
        clamp    = sum17[16] ^ sum17[15];
        acc_next = sum17[15:0];
        if (clamp) begin
            acc_next = sum17[16] ? 16'h8000 : 16'h7FFF;
        end
    end

    // Coefficient file: writable only while idle, out-of-range indices dropped.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if ((state == IDLE) && coef_we && ({1'b0, coef_addr} < TAPS_W)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Main sequencer: accept sample, run TAPS MAC cycles, hold result until the sink takes it.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state     <= IDLE;
            wptr      <= '0;
            k         <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                sample[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        sample[wptr] <= in_data;
                        acc          <= '0;
                        k            <= '0;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        state        <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= (k == LAST) ? '0 : k + 1'b1;
                    if (k == LAST) begin
                        out_data  <= acc_next;
                        out_valid <= 1'b1;
                        wptr      <= (wptr == LAST) ? '0 : wptr + 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_SAT_FLAG_EN
    logic sat_run;

    // Sticky clamp flag for the current sample, published alongside out_data and dropped with out_valid.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            sat_run <= 1'b0;
            out_sat <= 1'b0;
        end else if (accept) begin
            sat_run <= 1'b0;
        end else if (state == MAC) begin
            sat_run <= sat_run | clamp;
            if (k == LAST) begin
                out_sat <= sat_run | clamp;
            end
        end else if ((state == OUT) && out_ready) begin
            out_sat <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: vector table plus scoreboard, with hand sequences for
// reset, backpressure and reset during MAC.
// Provides a behavioural saturating multiplier on mul_a/mul_b.
module tb_fir_mac_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [15:0] coef_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_res;
    logic        busy;
`ifdef FIR_SAT_FLAG_EN
    logic        out_sat;
`endif

    always #5 clk = ~clk;

    fir_mac_sched #(.TAPS(4), .IW(2)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .mul_a           (mul_a),
        .mul_b           (mul_b),
        .mul_res         (mul_res),
        .busy            (busy)
`ifdef FIR_SAT_FLAG_EN
        ,
        .out_sat         (out_sat)
`endif
    );

    function automatic logic [15:0] satmul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        if (p > 32767)       return 16'h7FFF;
        else if (p < -32768) return 16'h8000;
        else                 return p[15:0];
    endfunction

    always_comb mul_res = satmul(mul_a, mul_b);

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
    } exp_t;

    typedef struct packed {
        logic             rst;
        logic             wr;
        logic [3:0][15:0] c;
        logic [15:0]      din;
        logic [15:0]      ex;
        logic             sat;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic wr,
                                input logic [15:0] c0, input logic [15:0] c1,
                                input logic [15:0] c2, input logic [15:0] c3,
                                input logic [15:0] din, input logic [15:0] ex,
                                input logic sat);
        vec_t v;
        v.rst = rst;
        v.wr  = wr;
        v.c   = {c3, c2, c1, c0};
        v.din = din;
        v.ex  = ex;
        v.sat = sat;
        return v;
    endfunction

    // Scoreboard: compare every transferred result against the oldest expectation.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {16'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", {16'd0, out_data}, {16'd0, e.data});
`ifdef FIR_SAT_FLAG_EN
                chk("out_sat", {31'd0, out_sat}, {31'd0, e.sat});
`endif
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rstn     = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 30);
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        exp_t e;
        if (v.rst) do_reset();
        if (v.wr) begin
            for (int i = 3; i >= 1; i--) begin
                @(posedge clk); #1;
                coef_we   = 1'b1;
                coef_addr = 2'(i);
                coef_data = v.c[i];
            end
        end
        @(posedge clk); #1;
        coef_we   = v.wr;
        coef_addr = 2'd0;
        coef_data = v.c[0];
        in_valid  = 1'b1;
        in_data   = v.din;
        e.data    = v.ex;
        e.sat     = v.sat;
        sb.push_back(e);
        wait_accept();
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_in_mac", {31'd0, busy}, 32'd1);
        end while (!out_valid && n < 30);
        chk("result_latency", n, 32'd5);
    endtask

    initial begin
        int n;
        int seen;
        exp_t e;

        rstn      = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        tbl[0]  = mk(1'b0, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd10, 16'd10,  1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd20, 16'd40,  1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd30, 16'd100, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd40, 16'd200, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd50, 16'd300, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1,  16'd431, 1'b0);
        tbl[6]  = mk(1'b1, 1'b1, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'd2, 16'h7FFF, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 16'h7FFF, 16'd0, 16'd0, 16'd0, 16'hFFFE, 16'h8000, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 16'd0, 16'd0, 16'hFFFE, 16'h8000, 1'b1);
        tbl[9]  = mk(1'b1, 1'b1, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'd1, 16'h4000, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'd1, 16'h7FFF, 1'b1);
        tbl[11] = mk(1'b0, 1'b1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd7, 16'd7,  1'b0);
        tbl[12] = mk(1'b0, 1'b1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd7, 16'd14, 1'b0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_mul_a",     {16'd0, mul_a},     32'd0);
        chk("rst_mul_b",     {16'd0, mul_b},     32'd0);
        chk("rst_out_data",  {16'd0, out_data},  32'd0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic FIR and delay-line wrap
        for (int i = 0; i <= 4; i++) run_vec(tbl[i]);

        // Backpressure: result held, input blocked, coefficient writes ignored
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'd60;
        e.data    = 16'd400;
        e.sat     = 1'b0;
        sb.push_back(e);
        wait_accept();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 30);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            coef_we   = 1'b1;
            coef_addr = 2'd0;
            coef_data = 16'd100;
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data",  {16'd0, out_data},  32'd400);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_mul_a",     {16'd0, mul_a},     32'd0);
        end
        @(posedge clk); #1;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        run_vec(tbl[5]);

        // Multiplier and accumulator saturation
        for (int i = 6; i <= 10; i++) run_vec(tbl[i]);

        // Reset during the second MAC cycle
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'd5;
        wait_accept();
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_busy",  {31'd0, busy},  32'd0);
        chk("midrst_mul_a", {16'd0, mul_a}, 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        @(posedge clk); #1 rstn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_valid", seen, 32'd0);
        run_vec(tbl[11]);
        run_vec(tbl[12]);

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
